// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-requester arbiter and sequencer in front of memory_bus. Port 0 is the
//   CPU core, port 1 a second master (DMA, boot loader, debug). Each access is
//   latched at grant and then runs for a fixed number of cycles. A one-cycle
//   ready pulse goes back to the owning port when the access is finished.
//
// Parameters
//   READ_LATENCY  : cycles from bus_address valid to bus_data_out sampled (1..15)
//   PRIORITY_MODE : 0 = round-robin tie-break, 1 = fixed priority (port 0 wins)
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   mX_req              : level request from port X
//   mX_we               : 1 = write, 0 = read
//   mX_address          : 16-bit address
//   mX_data_in          : 8-bit write data
//   mX_data_out         : 8-bit read data, held until the next read of port X
//   mX_ready            : one-cycle completion pulse
//   bus_address         : address to memory_bus
//   bus_data_in         : write data to memory_bus
//   bus_data_out        : read data from memory_bus
//   bus_write_enable    : write strobe, first ACCESS cycle of a write only
//   busy                : high while a transaction is in ACCESS or DONE
//   grant_id            : port owning the current or most recent transaction
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int READ_LATENCY  = 1,
    parameter int PRIORITY_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_address,
    input  logic [7:0]  m0_data_in,
    output logic [7:0]  m0_data_out,
    output logic        m0_ready,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_address,
    input  logic [7:0]  m1_data_in,
    output logic [7:0]  m1_data_out,
    output logic        m1_ready,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_data_in,
    input  logic [7:0]  bus_data_out,
    output logic        bus_write_enable,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Counter value on the last ACCESS cycle.
    localparam logic [3:0] LAST_CNT = 4'(READ_LATENCY - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  count_r;
    logic        latched_we_r;
    logic        last_grant_r;

    logic        req_any_s;
    logic        sel_port_s;
    logic        sel_we_s;
    logic [15:0] sel_address_s;
    logic [7:0]  sel_data_s;
    logic        grant_now_s;
    logic        access_last_s;

    logic        busy_nxt_s;
    logic        bus_we_nxt_s;
    logic        m0_ready_nxt_s;
    logic        m1_ready_nxt_s;

    // Arbitration: pick the port that would be granted if we were in IDLE.
    always_comb begin
        req_any_s  = m0_req | m1_req;
        sel_port_s = 1'b0;
        if (m0_req && m1_req) begin
            if (PRIORITY_MODE == 1) begin
                sel_port_s = 1'b0;
            end else begin
                // Round-robin: the port that did not win last time goes next.
                sel_port_s = ~last_grant_r;
            end
        end else if (m1_req) begin
            sel_port_s = 1'b1;
        end else begin
            sel_port_s = 1'b0;
        end

        if (sel_port_s) begin
            sel_we_s      = m1_we;
            sel_address_s = m1_address;
            sel_data_s    = m1_data_in;
        end else begin
            sel_we_s      = m0_we;
            sel_address_s = m0_address;
            sel_data_s    = m0_data_in;
        end

        grant_now_s   = (state_r == ST_IDLE) && req_any_s;
        access_last_s = (state_r == ST_ACCESS) && (count_r == LAST_CNT);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; DONE always returns to IDLE without re-arbitrating.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (count_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered status outputs, so
    // they line up with the state they describe.
    always_comb begin
        busy_nxt_s     = (state_nxt_s != ST_IDLE);
        // Write strobe only for the first ACCESS cycle, i.e. right after grant.
        if (grant_now_s) begin
            bus_we_nxt_s = sel_we_s;
        end else begin
            bus_we_nxt_s = 1'b0;
        end
        // grant_id is stable throughout ACCESS, so it selects the ready port.
        if (access_last_s) begin
            m0_ready_nxt_s = ~grant_id;
            m1_ready_nxt_s = grant_id;
        end else begin
            m0_ready_nxt_s = 1'b0;
            m1_ready_nxt_s = 1'b0;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy             <= 1'b0;
            bus_write_enable <= 1'b0;
            m0_ready         <= 1'b0;
            m1_ready         <= 1'b0;
        end else begin
            busy             <= busy_nxt_s;
            bus_write_enable <= bus_we_nxt_s;
            m0_ready         <= m0_ready_nxt_s;
            m1_ready         <= m1_ready_nxt_s;
        end
    end

    // Transaction latch: requester inputs are captured only at grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_address  <= 16'h0000;
            bus_data_in  <= 8'h00;
            latched_we_r <= 1'b0;
            grant_id     <= 1'b0;
            // Pretend port 1 won last so port 0 takes the first tie.
            last_grant_r <= 1'b1;
        end else if (grant_now_s) begin
            bus_address  <= sel_address_s;
            bus_data_in  <= sel_data_s;
            latched_we_r <= sel_we_s;
            grant_id     <= sel_port_s;
            last_grant_r <= sel_port_s;
        end else begin
            bus_address  <= bus_address;
            bus_data_in  <= bus_data_in;
            latched_we_r <= latched_we_r;
            grant_id     <= grant_id;
            last_grant_r <= last_grant_r;
        end
    end

    // Latency counter: cleared at grant, counts ACCESS cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (grant_now_s) begin
            count_r <= 4'd0;
        end else if (state_r == ST_ACCESS) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Read data capture on the last ACCESS cycle; writes leave data_out alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_data_out <= 8'h00;
            m1_data_out <= 8'h00;
        end else if (access_last_s && !latched_we_r) begin
            if (grant_id) begin
                m1_data_out <= bus_data_out;
            end else begin
                m0_data_out <= bus_data_out;
            end
        end else begin
            m0_data_out <= m0_data_out;
            m1_data_out <= m1_data_out;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed testbench. Three arbiters share the requester inputs:
//     instance 0 : READ_LATENCY=1, round-robin
//     instance 1 : READ_LATENCY=1, fixed priority
//     instance 2 : READ_LATENCY=3, round-robin
//   Each has its own small memory model (RAM below 0x4000, fixed ROM above).
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0;
    logic        m0_we = 1'b0;
    logic [15:0] m0_address = 16'h0000;
    logic [7:0]  m0_data_in = 8'h00;
    logic        m1_req = 1'b0;
    logic        m1_we = 1'b0;
    logic [15:0] m1_address = 16'h0000;
    logic [7:0]  m1_data_in = 8'h00;

    logic [2:0][7:0]  m0_data_out;
    logic [2:0]       m0_ready;
    logic [2:0][7:0]  m1_data_out;
    logic [2:0]       m1_ready;
    logic [2:0][15:0] bus_address;
    logic [2:0][7:0]  bus_data_in;
    logic [2:0][7:0]  bus_data_out;
    logic [2:0]       bus_write_enable;
    logic [2:0]       busy;
    logic [2:0]       grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [15:0] addr);
        case (addr)
            16'h4005: rom_byte = 8'hA9;
            16'h4033: rom_byte = 8'h33;
            16'h8002: rom_byte = 8'h5E;
            default:  rom_byte = addr[7:0] ^ addr[15:8];
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RL = (g == 2) ? 3 : 1;
        localparam int PM = (g == 1) ? 1 : 0;

        logic [7:0] ram [0:255];

        bus_arbiter #(
            .READ_LATENCY (RL),
            .PRIORITY_MODE(PM)
        ) dut (
            .clk             (clk),
            .reset           (reset),
            .m0_req          (m0_req),
            .m0_we           (m0_we),
            .m0_address      (m0_address),
            .m0_data_in      (m0_data_in),
            .m0_data_out     (m0_data_out[g]),
            .m0_ready        (m0_ready[g]),
            .m1_req          (m1_req),
            .m1_we           (m1_we),
            .m1_address      (m1_address),
            .m1_data_in      (m1_data_in),
            .m1_data_out     (m1_data_out[g]),
            .m1_ready        (m1_ready[g]),
            .bus_address     (bus_address[g]),
            .bus_data_in     (bus_data_in[g]),
            .bus_data_out    (bus_data_out[g]),
            .bus_write_enable(bus_write_enable[g]),
            .busy            (busy[g]),
            .grant_id        (grant_id[g])
        );

        // Memory model: RAM cleared while reset is high, written on the strobe.
        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            end else if (bus_write_enable[g] && (bus_address[g] < 16'h4000)) begin
                ram[bus_address[g][7:0]] <= bus_data_in[g];
            end
        end

        assign bus_data_out[g] = (bus_address[g] < 16'h4000) ?
                                 ram[bus_address[g][7:0]] : rom_byte(bus_address[g]);
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m0_req = 1'b0;
        m1_req = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        check_value("rst_busy",     32'(busy[0]), 32'h0);
        check_value("rst_we",       32'(bus_write_enable[0]), 32'h0);
        check_value("rst_addr",     32'(bus_address[0]), 32'h0);
        check_value("rst_din",      32'(bus_data_in[0]), 32'h0);
        check_value("rst_ready",    32'({m0_ready[0], m1_ready[0]}), 32'h0);
        check_value("rst_dout",     32'({m0_data_out[0], m1_data_out[0]}), 32'h0);
        check_value("rst_grant",    32'(grant_id[0]), 32'h0);
        do_reset();

        // ---------------- m0 read of ROM 0x4005 ----------------
        m0_req = 1'b1; m0_we = 1'b0; m0_address = 16'h4005;
        tick();
        m0_req = 1'b0;
        check_value("rd_addr",      32'(bus_address[0]), 32'h4005);
        check_value("rd_we",        32'(bus_write_enable[0]), 32'h0);
        check_value("rd_busy",      32'(busy[0]), 32'h1);
        check_value("rd_grant",     32'(grant_id[0]), 32'h0);
        check_value("rd_noready",   32'(m0_ready[0]), 32'h0);
        tick();
        check_value("rd_ready",     32'(m0_ready[0]), 32'h1);
        check_value("rd_m1ready",   32'(m1_ready[0]), 32'h0);
        check_value("rd_data",      32'(m0_data_out[0]), 32'hA9);
        check_value("rd_m1data",    32'(m1_data_out[0]), 32'h00);
        check_value("rd_done_we",   32'(bus_write_enable[0]), 32'h0);
        tick();
        check_value("rd_ready_end", 32'(m0_ready[0]), 32'h0);
        check_value("rd_idle_busy", 32'(busy[0]), 32'h0);
        check_value("rd_idle_addr", 32'(bus_address[0]), 32'h4005);

        // ---------------- m1 write 0x0010 <= 0x5C ----------------
        m1_req = 1'b1; m1_we = 1'b1; m1_address = 16'h0010; m1_data_in = 8'h5C;
        tick();
        m1_req = 1'b0;
        check_value("wr_we",        32'(bus_write_enable[0]), 32'h1);
        check_value("wr_addr",      32'(bus_address[0]), 32'h0010);
        check_value("wr_din",       32'(bus_data_in[0]), 32'h5C);
        check_value("wr_grant",     32'(grant_id[0]), 32'h1);
        tick();
        check_value("wr_we_off",    32'(bus_write_enable[0]), 32'h0);
        check_value("wr_ready",     32'({m0_ready[0], m1_ready[0]}), 32'h1);
        check_value("wr_m1data",    32'(m1_data_out[0]), 32'h00);
        tick();
        check_value("wr_ready_end", 32'(m1_ready[0]), 32'h0);
        m0_req = 1'b1; m0_we = 1'b0; m0_address = 16'h0010;
        tick();
        m0_req = 1'b0;
        tick();
        check_value("rb_ready",     32'(m0_ready[0]), 32'h1);
        check_value("rb_data",      32'(m0_data_out[0]), 32'h5C);
        tick();

        // ---------------- both requesting, six transactions ----------------
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_address = 16'h4005;
        m1_req = 1'b1; m1_we = 1'b0; m1_address = 16'h4033;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_value("rr_grant",   32'(grant_id[0]), 32'(i % 2));
            check_value("fp_grant",   32'(grant_id[1]), 32'h0);
            tick();
            check_value("rr_ready",   32'({m1_ready[0], m0_ready[0]}),
                        (i % 2 == 0) ? 32'h1 : 32'h2);
            check_value("fp_ready",   32'({m1_ready[1], m0_ready[1]}), 32'h1);
            tick();
            check_value("rr_gap",     32'({m1_ready[0], m0_ready[0]}), 32'h0);
            check_value("rr_idle",    32'(busy[0]), 32'h0);
        end
        check_value("rr_m1data",  32'(m1_data_out[0]), 32'h33);
        check_value("fp_m1data",  32'(m1_data_out[1]), 32'h00);
        m0_req = 1'b0; m1_req = 1'b0;

        // ---------------- READ_LATENCY=3 with address change ----------------
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_address = 16'h8002;
        tick();
        m0_address = 16'hFFFF;
        m0_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_value("l3_addr",   32'(bus_address[2]), 32'h8002);
            check_value("l3_busy",   32'(busy[2]), 32'h1);
            check_value("l3_noready", 32'(m0_ready[2]), 32'h0);
            check_value("l3_nodata", 32'(m0_data_out[2]), 32'h00);
            tick();
        end
        check_value("l3_ready",   32'(m0_ready[2]), 32'h1);
        check_value("l3_data",    32'(m0_data_out[2]), 32'h5E);
        tick();
        check_value("l3_end",     32'({busy[2], m0_ready[2]}), 32'h0);

        // ---------------- reset during an m1 write ----------------
        do_reset();
        m1_req = 1'b1; m1_we = 1'b1; m1_address = 16'h0010; m1_data_in = 8'h5C;
        tick();
        check_value("ar_we_pre",  32'(bus_write_enable[0]), 32'h1);
        check_value("ar_busy_pre", 32'(busy[0]), 32'h1);
        reset = 1'b1;
        #1;
        check_value("ar_we",      32'(bus_write_enable[0]), 32'h0);
        check_value("ar_busy",    32'(busy[0]), 32'h0);
        check_value("ar_ready",   32'(m1_ready[0]), 32'h0);
        check_value("ar_grant",   32'(grant_id[0]), 32'h0);
        m0_req = 1'b1; m0_we = 1'b0; m0_address = 16'h4005;
        #2;
        reset = 1'b0;
        tick();
        check_value("ar_first",   32'(grant_id[0]), 32'h0);
        check_value("ar_addr",    32'(bus_address[0]), 32'h4005);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        check_value("ar_m0ready", 32'({m1_ready[0], m0_ready[0]}), 32'h1);
        tick();

        // ---------------- write does not disturb data_out ----------------
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_address = 16'h4033;
        tick();
        m0_req = 1'b0;
        tick();
        check_value("wk_rd_data", 32'(m0_data_out[0]), 32'h33);
        tick();
        m0_req = 1'b1; m0_we = 1'b1; m0_address = 16'h0020; m0_data_in = 8'h77;
        tick();
        m0_req = 1'b0;
        check_value("wk_we",      32'(bus_write_enable[0]), 32'h1);
        tick();
        check_value("wk_ready",   32'(m0_ready[0]), 32'h1);
        check_value("wk_hold",    32'(m0_data_out[0]), 32'h33);
        tick();
        check_value("wk_hold2",   32'(m0_data_out[0]), 32'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-requester arbiter and sequencer in front of memory_bus.
- Lets the CPU core (port 0) and a second master share the single address/data/write_enable path into RAM, ROM and peripherals. The second master is a DMA engine, boot loader or debug port.
- Runs each access as a latched, fixed-latency transaction and returns a one-cycle ready pulse. This gives the codebase the "pause until ready" handshake that slow memories need.

Parameters:
- READ_LATENCY, 1, cycles from bus_address valid to bus_data_out sampled; legal range 1..15.
- PRIORITY_MODE, 0, tie-break rule: 0 = round-robin, 1 = fixed priority with port 0 winning.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  port 0 access request, level.
- m0_we  input  1  port 0 write (1) or read (0).
- m0_address  input  16  port 0 address.
- m0_data_in  input  8  port 0 write data.
- m0_data_out  output  8  port 0 read data (registered).
- m0_ready  output  1  port 0 transaction complete, one-cycle pulse.
- m1_req, m1_we, m1_address, m1_data_in, m1_data_out, m1_ready: same widths and meanings, for port 1.
- bus_address  output  16  to memory_bus address.
- bus_data_in  output  8  to memory_bus data_in.
- bus_data_out  input  8  from memory_bus data_out.
- bus_write_enable  output  1  to memory_bus write_enable.
- busy  output  1  high while in ACCESS or DONE.
- grant_id  output  1  port owning the current or most recent transaction.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - bus_write_enable=0; m0_ready=m1_ready=0; busy=0.
  - bus_address=0, bus_data_in=0; m0_data_out=m1_data_out=0.
  - grant_id=0; internal last_grant=1, so port 0 wins the first tie.
  - A transaction in flight is abandoned with no ready pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no req, stay.
  - If exactly one req, grant that port.
  - If both req: PRIORITY_MODE=0 grants the port != last_grant; PRIORITY_MODE=1 grants port 0.
  - On grant, latch that port's we/address/data_in into bus_address/bus_data_in/latched_we, set grant_id and last_grant, clear latency counter, go to ACCESS.
- ACCESS:
  - bus_address and bus_data_in hold the latched values for the whole state.
  - bus_write_enable = latched_we during the first ACCESS cycle only; it is 0 in all other cycles.
  - The counter increments each cycle. When counter == READ_LATENCY-1, go to DONE; for a read, also capture bus_data_out into the granted port's data_out register at that edge.
- DONE:
  - Granted port's ready=1 for exactly this cycle; the other port's ready stays 0.
  - Next state is always IDLE. The arbiter never re-arbitrates in DONE.
- Timing: request sampled in IDLE at edge T; bus driven cycles T+1..T+READ_LATENCY; ready high cycle T+READ_LATENCY+1; next grant no earlier than T+READ_LATENCY+2. With READ_LATENCY=1, back-to-back transactions take 3 cycles each.
- Requester rules:
  - Inputs are sampled only at grant; changes to req/address/data during ACCESS/DONE are ignored.
  - Dropping req after grant does not cancel the transaction.
  - Holding req through ready starts a new transaction, subject to arbitration, on the next IDLE cycle.
- Data output rules:
  - Writes never modify mX_data_out.
  - mX_data_out holds its value until that port's next read completes.
- busy=1 in ACCESS and DONE, 0 in IDLE.
- bus_address retains its last value in IDLE; memory_bus reads there are don't-care.
- Round-robin fairness: with both ports continuously requesting, grants alternate 0,1,0,1...; neither port waits more than one transaction.

Test Plan:
- Reset then m0 read 0x4005 (ROM returns 0xA9), READ_LATENCY=1 -> bus_address=0x4005 for 1 cycle, bus_write_enable=0, m0_ready pulses 2 cycles after grant, m0_data_out=0xA9, m1_data_out stays 0.
- m1 write 0x0010 <= 0x5C -> bus_write_enable high exactly 1 cycle with bus_address=0x0010, bus_data_in=0x5C; m1_ready pulses once; a subsequent m0 read of 0x0010 returns 0x5C.
- Both req held high for 6 transactions, PRIORITY_MODE=0 -> grant_id sequence 0,1,0,1,0,1 and each ready 3 cycles apart. With PRIORITY_MODE=1 -> all grants to port 0 while m0_req is held.
- READ_LATENCY=3, m0 read 0x8002 with m0_address changed to 0xFFFF mid-ACCESS -> bus_address stays 0x8002 for 3 cycles, data captured on the 3rd cycle, ready at grant+4.
- Assert reset during ACCESS of an m1 write -> bus_write_enable, busy and m1_ready drop immediately. After release with both req high, first grant goes to port 0.
- m0 read completes (data 0x33), then m0 write of 0x77 -> m0_data_out remains 0x33 after the write's ready.
